cw305_usb_bus_master: RTL and testbench

- Initiator side of the CW305 parallel USB register bus: converts byte-burst commands into usb_addr/usb_cen/usb_rdn/usb_wrn/usb_data cycles that the USB register front-end consumes.
- Used as an on-FPGA bus driver for loopback self-test of the register map and as the synthesizable bench master for register-block regressions.
- Timing is parameterised, so slow or marginal host strobes can be reproduced.

---
 rtl/cw305_usb_bus_master.sv | 221 ++++++++++++++++++++++
 tb/tb_cw305_usb_bus_master.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cw305_usb_bus_master.sv
// ---------------------------------------------------------------------------
// cw305_usb_bus_master
//
// Initiator for the CW305 parallel USB register bus. A command describes a
// read or write burst; each byte becomes one bus cycle of the form
// SETUP (cen low, address valid) -> STROBE (rdn or wrn low) -> HOLD
// (strobes high, cen low) -> GAP (cen high). Setup/strobe/hold lengths are
// parameters so that slow or marginal host timing can be reproduced.
//
// Optional build macro: USB_BUS_MASTER_STATS_EN adds saturating byte
// counters (stat_wr_bytes, stat_rd_bytes) and a synchronous stat_clear.
//
// Ports:
//   usb_clk, resetn        clock, asynchronous active-low reset
//   cmd_*                  burst command (valid/ready, write, addr, len-1)
//   wr_data/wr_valid/
//   wr_ready               write byte source; wr_ready pulses on acceptance
//   rd_data/rd_valid       read byte sink; rd_valid pulses once per byte
//   busy                   high whenever a burst is in progress
//   usb_addr/usb_dout/
//   usb_drive/usb_din      bus address, write data + output enable, read data
//   usb_cen/usb_rdn/usb_wrn active-low chip enable and strobes
// ---------------------------------------------------------------------------
module cw305_usb_bus_master #(
   parameter int pADDR_WIDTH   = 21,
   parameter int pBYTECNT_SIZE = 7,
   parameter int pSETUP        = 1,
   parameter int pSTROBE       = 2,
   parameter int pHOLD         = 1
) (
   input  logic                     usb_clk,
   input  logic                     resetn,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic                     cmd_write,
   input  logic [pADDR_WIDTH-1:0]   cmd_addr,
   input  logic [pBYTECNT_SIZE-1:0] cmd_len,
   input  logic [7:0]               wr_data,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   output logic [7:0]               rd_data,
   output logic                     rd_valid,
   output logic                     busy,
`ifdef USB_BUS_MASTER_STATS_EN
   input  logic                     stat_clear,
   output logic [15:0]              stat_wr_bytes,
   output logic [15:0]              stat_rd_bytes,
`endif
   output logic [pADDR_WIDTH-1:0]   usb_addr,
   output logic [7:0]               usb_dout,
   output logic                     usb_drive,
   input  logic [7:0]               usb_din,
   output logic                     usb_cen,
   output logic                     usb_rdn,
   output logic                     usb_wrn
);

   typedef enum logic [2:0] {
      S_IDLE, S_WDATA, S_SETUP, S_STROBE, S_HOLD, S_GAP
   } state_t;

   localparam logic [3:0] SETUP_LAST  = 4'(pSETUP - 1);
   localparam logic [3:0] STROBE_LAST = 4'(pSTROBE - 1);
   localparam logic [3:0] HOLD_LAST   = 4'(pHOLD - 1);

   state_t                   state_reg, state_next;
   logic [3:0]               phase_reg, phase_next;
   logic [pBYTECNT_SIZE-1:0] remaining_reg, remaining_next;
   logic [pADDR_WIDTH-1:0]   cur_addr_reg, cur_addr_next;
   logic                     write_reg, write_next;
   logic [pBYTECNT_SIZE-1:0] bytecnt_inc;

   logic [pADDR_WIDTH-1:0]   usb_addr_next;
   logic [7:0]               usb_dout_next, rd_data_next;
   logic                     usb_drive_next, usb_cen_next, usb_rdn_next, usb_wrn_next;
   logic                     rd_valid_next, wr_ready_next, busy_next, cmd_ready_next;
   logic                     bus_active;

   // Byte counter wraps inside the low address field; upper bits are fixed.
   assign bytecnt_inc = cur_addr_reg[pBYTECNT_SIZE-1:0] + 1'b1;

   // ---------------- state register + registered outputs -----------------
   always_ff @(posedge usb_clk or negedge resetn) begin
      if (!resetn) begin
         state_reg     <= S_IDLE;
         phase_reg     <= '0;
         remaining_reg <= '0;
         cur_addr_reg  <= '0;
         write_reg     <= 1'b0;
         usb_addr      <= '0;
         usb_dout      <= '0;
         usb_drive     <= 1'b0;
         usb_cen       <= 1'b1;
         usb_rdn       <= 1'b1;
         usb_wrn       <= 1'b1;
         rd_data       <= '0;
         rd_valid      <= 1'b0;
         wr_ready      <= 1'b0;
         busy          <= 1'b0;
         cmd_ready     <= 1'b1;
      end else begin
         state_reg     <= state_next;
         phase_reg     <= phase_next;
         remaining_reg <= remaining_next;
         cur_addr_reg  <= cur_addr_next;
         write_reg     <= write_next;
         usb_addr      <= usb_addr_next;
         usb_dout      <= usb_dout_next;
         usb_drive     <= usb_drive_next;
         usb_cen       <= usb_cen_next;
         usb_rdn       <= usb_rdn_next;
         usb_wrn       <= usb_wrn_next;
         rd_data       <= rd_data_next;
         rd_valid      <= rd_valid_next;
         wr_ready      <= wr_ready_next;
         busy          <= busy_next;
         cmd_ready     <= cmd_ready_next;
      end
   end

   // ---------------- next-state logic ------------------------------------
   always_comb begin
      state_next     = state_reg;
      phase_next     = phase_reg;
      remaining_next = remaining_reg;
      cur_addr_next  = cur_addr_reg;
      write_next     = write_reg;
      case (state_reg)
         S_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               write_next     = cmd_write;
               cur_addr_next  = cmd_addr;
               remaining_next = cmd_len;
               phase_next     = '0;
               state_next     = cmd_write ? S_WDATA : S_SETUP;
            end
         end
         S_WDATA: begin
            if (wr_valid) begin
               phase_next = '0;
               state_next = S_SETUP;
            end
         end
         S_SETUP: begin
            if (phase_reg == SETUP_LAST) begin
               phase_next = '0;
               state_next = S_STROBE;
            end else begin
               phase_next = phase_reg + 4'd1;
            end
         end
         S_STROBE: begin
            if (phase_reg == STROBE_LAST) begin
               phase_next = '0;
               state_next = S_HOLD;
            end else begin
               phase_next = phase_reg + 4'd1;
            end
         end
         S_HOLD: begin
            if (phase_reg == HOLD_LAST) begin
               phase_next = '0;
               state_next = S_GAP;
            end else begin
               phase_next = phase_reg + 4'd1;
            end
         end
         S_GAP: begin
            if (remaining_reg == '0) begin
               state_next = S_IDLE;
            end else begin
               remaining_next = remaining_reg - 1'b1;
               cur_addr_next  = {cur_addr_reg[pADDR_WIDTH-1:pBYTECNT_SIZE], bytecnt_inc};
               phase_next     = '0;
               state_next     = write_reg ? S_WDATA : S_SETUP;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // ---------------- output logic (values for the next cycle) -----------
   // Outputs are derived from the state being entered so that every bus pin
   // comes straight from a flop.
   always_comb begin
      bus_active     = (state_next == S_SETUP) || (state_next == S_STROBE) ||
                       (state_next == S_HOLD);
      usb_addr_next  = (state_next == S_SETUP) ? cur_addr_next : usb_addr;
      usb_dout_next  = ((state_reg == S_WDATA) && wr_valid) ? wr_data : usb_dout;
      wr_ready_next  = (state_reg == S_WDATA) && wr_valid;
      usb_cen_next   = !bus_active;
      usb_drive_next = bus_active && write_next;
      usb_wrn_next   = !((state_next == S_STROBE) && write_next);
      usb_rdn_next   = !((state_next == S_STROBE) && !write_next);
      // usb_din is sampled on the edge that closes the final strobe cycle.
      rd_valid_next  = (state_reg == S_STROBE) && (state_next == S_HOLD) && !write_reg;
      rd_data_next   = rd_valid_next ? usb_din : rd_data;
      busy_next      = (state_next != S_IDLE);
      cmd_ready_next = (state_next == S_IDLE);
   end

`ifdef USB_BUS_MASTER_STATS_EN
   // Byte counters advance in GAP, i.e. once per completed byte.
   always_ff @(posedge usb_clk or negedge resetn) begin
      if (!resetn) begin
         stat_wr_bytes <= '0;
         stat_rd_bytes <= '0;
      end else if (stat_clear) begin
         stat_wr_bytes <= '0;
         stat_rd_bytes <= '0;
      end else if (state_reg == S_GAP) begin
         if (write_reg) begin
            if (stat_wr_bytes != 16'hFFFF) stat_wr_bytes <= stat_wr_bytes + 16'd1;
         end else begin
            if (stat_rd_bytes != 16'hFFFF) stat_rd_bytes <= stat_rd_bytes + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_cw305_usb_bus_master.sv
// ---------------------------------------------------------------------------
// tb_cw305_usb_bus_master
//
// Directed bench for cw305_usb_bus_master at default parameters. Expected
// bus writes and read bytes are queued when a command is issued and popped
// by a monitor as the DUT produces them. A feeder supplies write bytes with
// optional per-byte stall, and usb_din is modelled as 8'h10 + address low byte.
// ---------------------------------------------------------------------------
module tb_cw305_usb_bus_master;

   logic        usb_clk = 1'b0;
   logic        resetn  = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_write = 1'b0;
   logic [20:0] cmd_addr = '0;
   logic [6:0]  cmd_len  = '0;
   logic [7:0]  wr_data;
   logic        wr_valid;
   logic        wr_ready;
   logic [7:0]  rd_data;
   logic        rd_valid;
   logic        busy;
   logic [20:0] usb_addr;
   logic [7:0]  usb_dout;
   logic        usb_drive;
   logic [7:0]  usb_din;
   logic        usb_cen, usb_rdn, usb_wrn;
`ifdef USB_BUS_MASTER_STATS_EN
   logic        stat_clear = 1'b0;
   logic [15:0] stat_wr_bytes, stat_rd_bytes;
`endif

   cw305_usb_bus_master dut (
      .usb_clk   (usb_clk),
      .resetn    (resetn),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_len   (cmd_len),
      .wr_data   (wr_data),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .busy      (busy),
`ifdef USB_BUS_MASTER_STATS_EN
      .stat_clear    (stat_clear),
      .stat_wr_bytes (stat_wr_bytes),
      .stat_rd_bytes (stat_rd_bytes),
`endif
      .usb_addr  (usb_addr),
      .usb_dout  (usb_dout),
      .usb_drive (usb_drive),
      .usb_din   (usb_din),
      .usb_cen   (usb_cen),
      .usb_rdn   (usb_rdn),
      .usb_wrn   (usb_wrn)
   );

   always #5 usb_clk = ~usb_clk;

   // Register-file model on the far side of the bus.
   assign usb_din = 8'h10 + usb_addr[7:0];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int t_accept = 0;
   logic cur_is_read = 1'b0;

   always @(posedge usb_clk) cyc <= cyc + 1;

   typedef struct {
      logic [20:0] addr;
      logic [7:0]  data;
   } wr_exp_t;
   typedef struct {
      logic [7:0] data;
      int         delay;
   } src_t;

   wr_exp_t    exp_wr_q[$];
   logic [7:0] exp_rd_q[$];
   int         rd_time_q[$];
   src_t       src_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic wr_exp_t mk_wr(input logic [20:0] a, input logic [7:0] d);
      wr_exp_t e;
      e.addr = a;
      e.data = d;
      return e;
   endfunction

   function automatic src_t mk_src(input logic [7:0] d, input int dly);
      src_t s;
      s.data  = d;
      s.delay = dly;
      return s;
   endfunction

   task automatic send_cmd(input logic w, input logic [20:0] a, input logic [6:0] len);
      @(negedge usb_clk);
      cmd_valid   = 1'b1;
      cmd_write   = w;
      cmd_addr    = a;
      cmd_len     = len;
      cur_is_read = !w;
      t_accept    = cyc;
      $display("cmd %s addr=%06h len=%0d", w ? "WR" : "RD", a, len);
      @(negedge usb_clk);
      cmd_valid   = 1'b0;
   endtask

   task automatic wait_idle(input int budget, output int n);
      n = 0;
      while (busy && n < budget) begin
         @(negedge usb_clk);
         n++;
      end
      chk("idle_reached", 32'(busy), 32'd0);
   endtask

   // Write byte feeder: each byte may be preceded by a stall of 'delay' cycles.
   initial begin : feeder
      int cnt;
      cnt      = 0;
      wr_valid = 1'b0;
      wr_data  = 8'h00;
      forever begin
         @(negedge usb_clk);
         if (!resetn) begin
            src_q.delete();
            cnt = 0;
         end
         if (wr_ready && src_q.size() > 0) begin
            src_q.delete(0);
            cnt = 0;
         end
         if (src_q.size() > 0 && cnt >= src_q[0].delay) begin
            wr_valid = 1'b1;
            wr_data  = src_q[0].data;
         end else begin
            wr_valid = 1'b0;
            if (src_q.size() > 0) cnt++;
         end
      end
   end

   // Bus monitor: scoreboard pops, strobe widths and bus invariants.
   initial begin : monitor
      int cen_run, wrn_run, rdn_run;
      logic prev_wrn;
      wr_exp_t e;
      logic [7:0] r;
      cen_run = 0; wrn_run = 0; rdn_run = 0; prev_wrn = 1'b1;
      forever begin
         @(negedge usb_clk);
         if (!resetn) begin
            cen_run = 0; wrn_run = 0; rdn_run = 0; prev_wrn = 1'b1;
         end else begin
            chk("inv_rd_wr_overlap", 32'(!(!usb_rdn && !usb_wrn)), 32'd1);
            chk("inv_strobe_without_cen", 32'(!((!usb_rdn || !usb_wrn) && usb_cen)), 32'd1);
            chk("inv_drive_on_read", 32'(!(usb_drive && cur_is_read)), 32'd1);

            if (!usb_wrn && prev_wrn) begin
               chk("wr_expected_pending", 32'(exp_wr_q.size() > 0), 32'd1);
               if (exp_wr_q.size() > 0) begin
                  e = exp_wr_q.pop_front();
                  $display("bus write addr=%06h data=%02h drive=%0b", usb_addr, usb_dout, usb_drive);
                  chk("wr_addr", 32'(usb_addr), 32'(e.addr));
                  chk("wr_data", 32'(usb_dout), 32'(e.data));
                  chk("wr_drive", 32'(usb_drive), 32'd1);
               end
            end
            prev_wrn = usb_wrn;

            if (rd_valid) begin
               chk("rd_expected_pending", 32'(exp_rd_q.size() > 0), 32'd1);
               if (exp_rd_q.size() > 0) begin
                  r = exp_rd_q.pop_front();
                  $display("read byte data=%02h cyc=%0d", rd_data, cyc);
                  chk("rd_data", 32'(rd_data), 32'(r));
               end
               rd_time_q.push_back(cyc);
            end

            if (!usb_cen) cen_run++;
            else if (cen_run != 0) begin
               chk("cen_low_cycles", 32'(cen_run), 32'd4);
               cen_run = 0;
            end
            if (!usb_wrn) wrn_run++;
            else if (wrn_run != 0) begin
               chk("wrn_low_cycles", 32'(wrn_run), 32'd2);
               wrn_run = 0;
            end
            if (!usb_rdn) rdn_run++;
            else if (rdn_run != 0) begin
               chk("rdn_low_cycles", 32'(rdn_run), 32'd2);
               rdn_run = 0;
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish errors=%0d checks=%0d", errors, checks);
      $fatal(1, "simulation did not complete");
   end

   initial begin : stimulus
      int n, k;

      // ---------------- reset state ----------------
      repeat (3) @(negedge usb_clk);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_cen",       32'(usb_cen),   32'd1);
      chk("rst_rdn",       32'(usb_rdn),   32'd1);
      chk("rst_wrn",       32'(usb_wrn),   32'd1);
      chk("rst_drive",     32'(usb_drive), 32'd0);
      chk("rst_addr",      32'(usb_addr),  32'd0);
      chk("rst_dout",      32'(usb_dout),  32'd0);
      chk("rst_rd_data",   32'(rd_data),   32'd0);
      chk("rst_rd_valid",  32'(rd_valid),  32'd0);
      chk("rst_wr_ready",  32'(wr_ready),  32'd0);
      resetn = 1'b1;
      repeat (2) @(negedge usb_clk);

      // ---------------- single write ----------------
      exp_wr_q.push_back(mk_wr(21'h000105, 8'hA5));
      src_q.push_back(mk_src(8'hA5, 0));
      send_cmd(1'b1, 21'h000105, 7'd0);
      wait_idle(50, n);
      // 1 WDATA cycle + 5-cycle byte period
      chk("wr1_busy_cycles", 32'(n), 32'd6);
      chk("wr1_cmd_ready", 32'(cmd_ready), 32'd1);

      // ---------------- read burst ----------------
      rd_time_q.delete();
      for (int i = 0; i < 4; i++) exp_rd_q.push_back(8'h10 + 8'(i));
      send_cmd(1'b0, 21'h000200, 7'd3);
      wait_idle(100, n);
      chk("rd_busy_cycles", 32'(n), 32'd20);
      chk("rd_count", 32'(rd_time_q.size()), 32'd4);
      for (int i = 0; i < rd_time_q.size() && i < 4; i++)
         chk("rd_valid_timing", 32'(rd_time_q[i] - t_accept), 32'(4 + 5 * i));

      // ---------------- wrap of byte counter ----------------
      exp_wr_q.push_back(mk_wr(21'h00037E, 8'h11));
      exp_wr_q.push_back(mk_wr(21'h00037F, 8'h22));
      exp_wr_q.push_back(mk_wr(21'h000300, 8'h33));
      exp_wr_q.push_back(mk_wr(21'h000301, 8'h44));
      src_q.push_back(mk_src(8'h11, 0));
      src_q.push_back(mk_src(8'h22, 0));
      src_q.push_back(mk_src(8'h33, 0));
      src_q.push_back(mk_src(8'h44, 0));
      send_cmd(1'b1, 21'h00037E, 7'd3);
      wait_idle(100, n);
      chk("wrap_busy_cycles", 32'(n), 32'd24);

      // ---------------- write stall ----------------
      exp_wr_q.push_back(mk_wr(21'h000040, 8'hC0));
      exp_wr_q.push_back(mk_wr(21'h000041, 8'hC1));
      exp_wr_q.push_back(mk_wr(21'h000042, 8'hC2));
      src_q.push_back(mk_src(8'hC0, 0));
      src_q.push_back(mk_src(8'hC1, 10));
      src_q.push_back(mk_src(8'hC2, 0));
      send_cmd(1'b1, 21'h000040, 7'd2);
      k = 0;
      do begin
         @(negedge usb_clk);
         k++;
      end while (!wr_ready && k < 20);
      chk("stall_first_ack", 32'(wr_ready), 32'd1);
      repeat (5) @(negedge usb_clk);
      // Now parked in WDATA waiting for the stalled byte.
      for (int i = 0; i < 4; i++) begin
         chk("stall_bus_idle", 32'({busy, usb_cen, usb_wrn, usb_rdn, wr_ready}), 32'b11110);
         @(negedge usb_clk);
      end
      wait_idle(100, n);

      // ---------------- reset during STROBE of a read ----------------
      for (int i = 0; i < 4; i++) exp_rd_q.push_back(8'h10 + 8'(i));
      send_cmd(1'b0, 21'h000200, 7'd3);
      k = 0;
      while (usb_rdn && k < 20) begin
         @(negedge usb_clk);
         k++;
      end
      chk("rst_test_strobe_seen", 32'(usb_rdn), 32'd0);
      resetn = 1'b0;
      #1;
      chk("async_rst_cen", 32'(usb_cen), 32'd1);
      chk("async_rst_rdn", 32'(usb_rdn), 32'd1);
      chk("async_rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("async_rst_busy", 32'(busy), 32'd0);
      exp_rd_q.delete();
      for (int i = 0; i < 3; i++) begin
         @(negedge usb_clk);
         chk("rst_hold_rd_valid", 32'(rd_valid), 32'd0);
      end
      resetn = 1'b1;
      @(negedge usb_clk);
      chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("post_rst_rd_valid", 32'(rd_valid), 32'd0);
      exp_rd_q.push_back(8'h20);
      send_cmd(1'b0, 21'h000210, 7'd0);
      wait_idle(50, n);
      chk("post_rst_read_cycles", 32'(n), 32'd5);

`ifdef USB_BUS_MASTER_STATS_EN
      // ---------------- statistics counters ----------------
      @(negedge usb_clk);
      stat_clear = 1'b1;
      @(negedge usb_clk);
      stat_clear = 1'b0;
      chk("stat_wr_cleared", 32'(stat_wr_bytes), 32'd0);
      chk("stat_rd_cleared", 32'(stat_rd_bytes), 32'd0);
      for (int i = 0; i < 3; i++) begin
         exp_wr_q.push_back(mk_wr(21'h000010 + 21'(i), 8'h50 + 8'(i)));
         src_q.push_back(mk_src(8'h50 + 8'(i), 0));
      end
      send_cmd(1'b1, 21'h000010, 7'd2);
      wait_idle(100, n);
      exp_rd_q.push_back(8'h30);
      exp_rd_q.push_back(8'h31);
      send_cmd(1'b0, 21'h000020, 7'd1);
      wait_idle(100, n);
      @(negedge usb_clk);
      chk("stat_wr_bytes", 32'(stat_wr_bytes), 32'd3);
      chk("stat_rd_bytes", 32'(stat_rd_bytes), 32'd2);
      stat_clear = 1'b1;
      @(negedge usb_clk);
      stat_clear = 1'b0;
      chk("stat_wr_after_clear", 32'(stat_wr_bytes), 32'd0);
      chk("stat_rd_after_clear", 32'(stat_rd_bytes), 32'd0);
`endif

      // ---------------- drain ----------------
      repeat (3) @(negedge usb_clk);
      chk("wr_scoreboard_empty", 32'(exp_wr_q.size()), 32'd0);
      chk("rd_scoreboard_empty", 32'(exp_rd_q.size()), 32'd0);
      chk("final_cmd_ready", 32'(cmd_ready), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
